// File: rtl/ooo_types_pkg.sv
// Shared out-of-order core types: default widths, CDB packet layout and FU indices.
package ooo_types_pkg;

  localparam int NUM_FU = 4;
  localparam int DATA_W = 32;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int ROB_W  = 5;

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [AREG_W-1:0] rd;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
  } cdb_pkt_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2,
    FU_BR  = 2'd3
  } fu_idx_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Shared with the issue scheduler.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    // Scan farthest offset first so the requester nearest to ptr overwrites the rest.
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      idx = sum[IDX_W-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per FU, round-robin pick, registered CDB.
// Optional CDB_STALL_CNT_EN adds a saturating count of cycles with two or more buffered results.
module cdb_arbiter #(
  parameter int NUM_FU = ooo_types_pkg::NUM_FU,
  parameter int DATA_W = ooo_types_pkg::DATA_W,
  parameter int PREG_W = ooo_types_pkg::PREG_W,
  parameter int AREG_W = ooo_types_pkg::AREG_W,
  parameter int ROB_W  = ooo_types_pkg::ROB_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          fu_valid,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic [NUM_FU*PREG_W-1:0]   fu_pd,
  input  logic [NUM_FU*AREG_W-1:0]   fu_rd,
  input  logic [NUM_FU*ROB_W-1:0]    fu_rob,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  output logic                       cdb_valid,
  output logic [PREG_W-1:0]          cdb_pd,
  output logic [AREG_W-1:0]          cdb_rd,
  output logic [ROB_W-1:0]           cdb_rob,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       cdb_regf_we,
  output logic [$clog2(NUM_FU)-1:0]  cdb_grant_id
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [31:0]                cdb_conflict_cnt
`endif
);
  import ooo_types_pkg::*;

  localparam int IDX_W = $clog2(NUM_FU);

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [AREG_W-1:0] rd;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
  } pkt_t;

  logic [NUM_FU-1:0] buf_valid_q, buf_valid_d, grant;
  pkt_t              buf_q [NUM_FU];
  pkt_t              buf_d [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, grant_idx;
  logic [IDX_W-1:0]  cdb_grant_q, cdb_grant_d;
  logic              cdb_valid_q, cdb_valid_d;
  pkt_t              cdb_pkt_q, cdb_pkt_d;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req       (buf_valid_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A buffer being drained this cycle can be refilled at the same edge.
  assign fu_ready = ~buf_valid_q | grant;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_pkt_d   = cdb_pkt_q;
    cdb_grant_d = cdb_grant_q;
    if (flush) begin
      buf_valid_d = '0;
    end else begin
      if (|grant) begin
        cdb_valid_d            = 1'b1;
        cdb_pkt_d              = buf_q[grant_idx];
        cdb_grant_d            = grant_idx;
        buf_valid_d[grant_idx] = 1'b0;
        rr_ptr_d = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          buf_valid_d[i]  = 1'b1;
          buf_d[i].pd     = fu_pd[i*PREG_W +: PREG_W];
          buf_d[i].rd     = fu_rd[i*AREG_W +: AREG_W];
          buf_d[i].rob    = fu_rob[i*ROB_W +: ROB_W];
          buf_d[i].data   = fu_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= '0;
      for (int i = 0; i < NUM_FU; i++) buf_q[i] <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      cdb_grant_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      for (int i = 0; i < NUM_FU; i++) buf_q[i] <= buf_d[i];
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_pkt_q   <= cdb_pkt_d;
      cdb_grant_q <= cdb_grant_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_pd       = cdb_pkt_q.pd;
  assign cdb_rd       = cdb_pkt_q.rd;
  assign cdb_rob      = cdb_pkt_q.rob;
  assign cdb_data     = cdb_pkt_q.data;
  assign cdb_grant_id = cdb_grant_q;
  // Writes to the architectural zero register are suppressed at the register file.
  assign cdb_regf_we  = cdb_valid_q && (cdb_pkt_q.rd != '0);

`ifdef CDB_STALL_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        multi_valid;

  always_comb begin
    // Clearing the lowest set bit leaves something only if two or more are set.
    multi_valid    = |(buf_valid_q & (buf_valid_q - 1'b1));
    conflict_cnt_d = conflict_cnt_q;
    if (multi_valid && (conflict_cnt_q != 32'hFFFF_FFFF)) conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_cnt_q <= '0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign cdb_conflict_cnt = conflict_cnt_q;
`endif

endmodule
